// File: rtl/video_timing_gen_pkg.sv
// Shared video package: coordinate widths, default 640x480 timing and the
// bundle of sync/enable bits carried through the output delay chain.
package video_timing_gen_pkg;

  localparam int VIDEO_X_BITWIDTH = 10;
  localparam int VIDEO_Y_BITWIDTH = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Polarity-free "active" flags; sync polarity is applied at the outputs.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_bits_t;

  function automatic bit fits_width(input int value, input int bits);
    return (value >= 0) && (value < (1 << bits));
  endfunction

endpackage

// File: rtl/video_timing_gen_sync.sv
// sync_delay: DEPTH-deep, en-gated shift chain for the de/hs/vs active flags.
// DEPTH = 0 is a pass-through forced inactive while reset is held.
module sync_delay
  import video_timing_gen_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  sync_bits_t d,
  output sync_bits_t q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, en};
    assign q = rst ? d : '0;
  end else begin : g_chain
    sync_bits_t chain [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
      end else if (en) begin
        chain[0] <= d;
        for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      end
    end

    assign q = chain[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered x/y counters, frame counter, start
// pulses and de/hs/vs delayed to line up with the pixel generator pipeline.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic [VIDEO_X_BITWIDTH-1:0] x,
  output logic [VIDEO_Y_BITWIDTH-1:0] y,
  output logic                        de,
  output logic                        hs,
  output logic                        vs,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [7:0]                  frame_cnt
);

  localparam int XW      = VIDEO_X_BITWIDTH;
  localparam int YW      = VIDEO_Y_BITWIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  if (!fits_width(H_TOTAL - 1, XW)) begin : g_bad_x_width
    $error("video_timing_gen: H_TOTAL-1 does not fit VIDEO_X_BITWIDTH");
  end
  if (!fits_width(V_TOTAL - 1, YW)) begin : g_bad_y_width
    $error("video_timing_gen: V_TOTAL-1 does not fit VIDEO_Y_BITWIDTH");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("video_timing_gen: PIPE_DELAY must be 0..4");
  end

  logic       x_wrap;
  logic       y_wrap;
  sync_bits_t raw;
  sync_bits_t dly;

  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (x_wrap) begin
        x <= '0;
        if (y_wrap) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_comb begin
    raw    = '0;
    raw.de = (x < X_ACT) && (y < Y_ACT);
    raw.hs = (x >= HS_START) && (x < HS_END);
    raw.vs = (y >= VS_START) && (y < VS_END);
  end

  sync_delay #(
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  (raw),
    .q  (dly)
  );

  assign de = dly.de;
  assign hs = SYNC_POL ? dly.hs : ~dly.hs;
  assign vs = SYNC_POL ? dly.vs : ~dly.vs;

  // Gated by rst so an en strobe during reset cannot produce a pulse.
  assign line_start  = rst & en & (x == '0);
  assign frame_start = line_start & (y == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised-strobe bench for video_timing_gen on a reduced raster, three
// configurations in lockstep, checked against a position-based model.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  localparam int HA = 8, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int W  = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic [7:0] fca, fcb, fcc;
  logic       dea, hsa, vsa, lsa, fsa;
  logic       deb, hsb, vsb, lsb, fsb;
  logic       dec, hsc, vsc, lsc, fsc;

  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0), .PIPE_DELAY(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(xa), .y(ya), .de(dea), .hs(hsa), .vs(vsa),
    .line_start(lsa), .frame_start(fsa), .frame_cnt(fca));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(xb), .y(yb), .de(deb), .hs(hsb), .vs(vsb),
    .line_start(lsb), .frame_start(fsb), .frame_cnt(fcb));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0), .PIPE_DELAY(3)) dut_c (
    .clk(clk), .rst(rst), .en(en), .x(xc), .y(yc), .de(dec), .hs(hsc), .vs(vsc),
    .line_start(lsc), .frame_start(fsc), .frame_cnt(fcc));

  logic [32:0] obs_a, obs_b, obs_c;
  assign obs_a = {xa, ya, fca, dea, hsa, vsa, lsa, fsa};
  assign obs_b = {xb, yb, fcb, deb, hsb, vsb, lsb, fsb};
  assign obs_c = {xc, yc, fcc, dec, hsc, vsc, lsc, fsc};

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // en cycles completed since reset release

  // Expected outputs of one instance at raster position pos.
  function automatic logic [32:0] model(input int pos, input bit r, input bit e,
                                        input int d, input bit pol);
    int  hx, vy, fc, dp, dx, dy;
    bit  de_b, hs_a, vs_a, ls, fs;
    if (!r) return {10'd0, 10'd0, 8'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0};
    hx = pos % HT;
    vy = (pos / HT) % VT;
    fc = (pos / FT) % 256;
    de_b = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
    if (pos >= d) begin
      dp   = pos - d;
      dx   = dp % HT;
      dy   = (dp / HT) % VT;
      de_b = (dx < HA) && (dy < VA);
      hs_a = (dx >= HA + HF) && (dx < HA + HF + HSY);
      vs_a = (dy >= VA + VF) && (dy < VA + VF + VSY);
    end
    ls = e && (hx == 0);
    fs = ls && (vy == 0);
    return {10'(hx), 10'(vy), 8'(fc), de_b, hs_a ? pol : ~pol, vs_a ? pol : ~pol, ls, fs};
  endfunction

  task automatic drive(input bit r, input bit e);
    @(posedge clk);
    #1;
    if (rst && en) k++;
    if (!r) k = 0;
    rst = r;
    en  = e;
    exp_q.push_back({model(k, r, e, 1, 1'b0), model(k, r, e, 0, 1'b1),
                     model(k, r, e, 3, 1'b0)});
  endtask

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s t=%0t: got x=%0d y=%0d fc=%0d de/hs/vs/ls/fs=%b, want x=%0d y=%0d fc=%0d de/hs/vs/ls/fs=%b",
                 name, $time, act[32:23], act[22:13], act[12:5], act[4:0],
                 exp[32:23], exp[22:13], exp[12:5], exp[4:0]);
    end
  endtask

  // Monitor: every cycle presents outputs, compared against the queued entry.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cfg_pol0_d1", obs_a, e[98:66]);
      check("cfg_pol1_d0", obs_b, e[65:33]);
      check("cfg_pol0_d3", obs_c, e[32:0]);
    end
  end

  initial begin
    repeat (3) drive(1'b0, 1'($urandom_range(0, 1)));
    // Past 256 frames so frame_cnt wraps 255 -> 0.
    while (k < 256 * FT + 30) drive(1'b1, $urandom_range(0, 3) != 0);
    // Reach mid-frame, then reset asynchronously.
    for (int i = 0; i < 400; i++) begin
      if ((k % HT == 5) && ((k / HT) % VT == 2)) break;
      drive(1'b1, $urandom_range(0, 3) != 0);
    end
    repeat (4) drive(1'b0, 1'($urandom_range(0, 1)));
    drive(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2) == 1);
    repeat (100) drive(1'b1, 1'($urandom_range(0, 1)));
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
